// File: rtl/voice_sched.sv
// Voice scheduler: round-robin channel scan plus a 3-cycle note-event FSM that
// allocates, retriggers and releases voices in per-channel note/tuning tables.
module voice_sched #(
    parameter int NUM_BITS     = 32,
    parameter int NUM_CHANNELS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_on,
    input  logic [6:0]              ev_note,
    input  logic [NUM_BITS-1:0]     ev_tw,
    output logic [NUM_CHANNELS-1:0] acc_en,
    output logic [NUM_CHANNELS-1:0] acc_clr,
    output logic [NUM_CHANNELS-1:0] curr_note,
    output logic [NUM_BITS-1:0]     tuning_word,
    output logic [NUM_CHANNELS-1:0] ch_active,
    output logic                    frame_start,
    output logic                    drop
);

    localparam int IDX_W = $clog2(NUM_CHANNELS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        COMMIT = 2'd2
    } state_e;

    function automatic logic [NUM_CHANNELS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_CHANNELS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    ev_ready_q;
    logic                    lat_on_q;
    logic [6:0]              lat_note_q;
    logic [NUM_BITS-1:0]     lat_tw_q;
    logic                    match_hit_q, free_hit_q;
    logic [IDX_W-1:0]        match_idx_q, free_idx_q;
    logic [NUM_CHANNELS-1:0] active_q;
    logic [6:0]              note_q [NUM_CHANNELS];
    logic [NUM_BITS-1:0]     tw_q   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] curr_note_q, acc_en_q, acc_clr_q;
    logic [NUM_BITS-1:0]     tuning_word_q;
    logic                    frame_start_q, drop_q;

    logic                    accept_s;
    logic                    match_hit_s, free_hit_s;
    logic [IDX_W-1:0]        match_idx_s, free_idx_s;
    logic                    on_wr_s, off_clr_s, drop_s;
    logic [IDX_W-1:0]        wr_idx_s;

    // Scan index: free-running modulo NUM_CHANNELS.
    always_comb begin
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end

    // Lowest matching active channel and lowest free channel (descending loop keeps the lowest).
    always_comb begin
        match_hit_s = 1'b0;
        match_idx_s = '0;
        free_hit_s  = 1'b0;
        free_idx_s  = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            match_idx_s = (active_q[i] && (note_q[i] == lat_note_q)) ? IDX_W'(i) : match_idx_s;
            match_hit_s = match_hit_s | (active_q[i] && (note_q[i] == lat_note_q));
            free_idx_s  = (!active_q[i]) ? IDX_W'(i) : free_idx_s;
            free_hit_s  = free_hit_s | !active_q[i];
        end
    end

    // Event FSM next state and commit decode.
    always_comb begin
        state_d   = state_q;
        accept_s  = 1'b0;
        on_wr_s   = 1'b0;
        off_clr_s = 1'b0;
        drop_s    = 1'b0;
        wr_idx_s  = match_hit_q ? match_idx_q : free_idx_q;
        case (state_q)
            IDLE: begin
                if (ev_valid && ev_ready_q) begin
                    accept_s = 1'b1;
                    state_d  = LOOKUP;
                end else begin
                    state_d  = IDLE;
                end
            end
            LOOKUP: state_d = COMMIT;
            COMMIT: begin
                state_d   = IDLE;
                on_wr_s   = lat_on_q && (match_hit_q || free_hit_q);
                off_clr_s = !lat_on_q && match_hit_q;
                drop_s    = lat_on_q && !match_hit_q && !free_hit_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, scan index and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            ev_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ev_ready_q <= (state_d == IDLE);
        end
    end

    // Event latch and lookup result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_on_q    <= 1'b0;
            lat_note_q  <= 7'd0;
            lat_tw_q    <= '0;
            match_hit_q <= 1'b0;
            match_idx_q <= '0;
            free_hit_q  <= 1'b0;
            free_idx_q  <= '0;
        end else begin
            if (accept_s) begin
                lat_on_q   <= ev_on;
                lat_note_q <= ev_note;
                lat_tw_q   <= ev_tw;
            end
            if (state_q == LOOKUP) begin
                match_hit_q <= match_hit_s;
                match_idx_q <= match_idx_s;
                free_hit_q  <= free_hit_s;
                free_idx_q  <= free_idx_s;
            end
        end
    end

    // Voice tables, written only at the COMMIT edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                note_q[i] <= 7'd0;
                tw_q[i]   <= '0;
            end
        end else if (on_wr_s) begin
            active_q[wr_idx_s] <= 1'b1;
            note_q[wr_idx_s]   <= lat_note_q;
            tw_q[wr_idx_s]     <= lat_tw_q;
        end else if (off_clr_s) begin
            active_q[match_idx_q] <= 1'b0;
        end
    end

    // Registered scan outputs sample the tables before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_note_q   <= '0;
            tuning_word_q <= '0;
            acc_en_q      <= '0;
            frame_start_q <= 1'b0;
            acc_clr_q     <= '0;
            drop_q        <= 1'b0;
        end else begin
            curr_note_q   <= onehot(idx_q);
            tuning_word_q <= tw_q[idx_q];
            acc_en_q      <= onehot(idx_q) & {NUM_CHANNELS{active_q[idx_q]}};
            frame_start_q <= (idx_q == '0);
            acc_clr_q     <= on_wr_s ? onehot(wr_idx_s) : '0;
            drop_q        <= drop_s;
        end
    end

    assign ev_ready    = ev_ready_q;
    assign acc_en      = acc_en_q;
    assign acc_clr     = acc_clr_q;
    assign curr_note   = curr_note_q;
    assign tuning_word = tuning_word_q;
    assign ch_active   = active_q;
    assign frame_start = frame_start_q;
    assign drop        = drop_q;

endmodule

// File: doc/voice_sched.md
VOICE_SCHED -- requirements
Module: voice_sched

Interface
REQ-001 SHALL have parameter NUM_BITS, default 32, phase-accumulator/tuning-word width.
REQ-002 SHALL have parameter NUM_CHANNELS, default 16, number of voices (>=2).
REQ-003 SHALL have port clk  input  1  single clock; one clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ev_valid  input  1  note event present.
REQ-006 SHALL have port ev_ready  output  1  event accepted when ev_valid && ev_ready at a rising edge.
REQ-007 SHALL have port ev_on  input  1  1 = note-on, 0 = note-off.
REQ-008 SHALL have port ev_note  input  7  MIDI note number.
REQ-009 SHALL have port ev_tw  input  NUM_BITS  tuning word for a note-on; ignored for note-off.
REQ-010 SHALL have port acc_en  output  NUM_CHANNELS  per-channel accumulate enable.
REQ-011 SHALL have port acc_clr  output  NUM_CHANNELS  per-channel phase clear, one-cycle pulse.
REQ-012 SHALL have port curr_note  output  NUM_CHANNELS  one-hot channel currently being serviced.
REQ-013 SHALL have port tuning_word  output  NUM_BITS  tuning word of the serviced channel.
REQ-014 SHALL have port ch_active  output  NUM_CHANNELS  voice-allocated flags.
REQ-015 SHALL have port frame_start  output  1  high in the cycle channel 0 is serviced.
REQ-016 SHALL have port drop  output  1  one-cycle pulse when a note-on finds no channel.

Function
REQ-017 SHALL hold per-channel tables: active bit, note[6:0], tw[NUM_BITS-1:0].
REQ-018 Scan: index idx SHALL count 0..NUM_CHANNELS-1 and wrap to 0, advancing every cycle, unconditionally.
REQ-019 Scan outputs SHALL be registered, sampled from the current idx: curr_note = one-hot(idx); tuning_word = tw[idx]; acc_en = one-hot(idx) masked by active[idx]; frame_start = (idx==0).
REQ-020 Scan outputs SHALL sample table contents from before any same-cycle table write; a write SHALL become visible at the next service of that channel.
REQ-021 Event FSM states SHALL be IDLE, LOOKUP and COMMIT; ev_ready SHALL be 1 only in IDLE.
REQ-022 IDLE SHALL latch ev_on/ev_note/ev_tw on acceptance, then go to LOOKUP.
REQ-023 LOOKUP SHALL register, in one cycle, a match (lowest active channel with note == latched note) and a free slot (lowest inactive channel), then go to COMMIT.
REQ-024 COMMIT, note-on with match: SHALL overwrite tw of the matched channel and retrigger it; active stays 1.
REQ-025 COMMIT, note-on without match but with a free channel: SHALL set active, note and tw for that channel.
REQ-026 COMMIT, note-on with no match and no free channel: SHALL leave tables unchanged and pulse drop.
REQ-027 COMMIT, note-off with match: SHALL clear active for that channel; note-off without match SHALL be a no-op with no drop.
REQ-028 acc_clr SHALL pulse the written channel's bit, registered, in the cycle after COMMIT, for note-on writes (new or retrigger) only.
REQ-029 drop SHALL be registered and SHALL appear in the same cycle as acc_clr would appear.
REQ-030 FSM SHALL return from COMMIT to IDLE; event throughput SHALL be 1 per 3 cycles, with ev_ready high again 3 cycles after acceptance.
REQ-031 ch_active SHALL equal the active table directly, updated at the COMMIT edge.

Reset
REQ-032 While rst is high: idx SHALL be 0, all tables SHALL be cleared, FSM SHALL be IDLE, and every output (including ev_ready) SHALL be 0.
REQ-033 On the first edge after rst deasserts: curr_note SHALL be 1 and frame_start SHALL be 1; ev_ready SHALL be 1 from that cycle.
REQ-034 rst asserted mid-event SHALL discard the event, with no acc_clr and no drop.

Verification
REQ-035 Reset release, no events -> curr_note cycles 0x0001,0x0002..0x8000,0x0001; frame_start every 16 cycles; acc_en stays 0.
REQ-036 Note-on note 60, tw 0x0123_4567 -> ch_active=0x0001; acc_clr=0x0001 for 1 cycle; thereafter tuning_word=0x0123_4567 whenever curr_note=0x0001, and acc_en=0x0001 in those cycles.
REQ-037 Note-ons for notes 60 then 64, then note-off 60 -> ch_active goes 0x0001, then 0x0003, then 0x0002; the next note-on lands in channel 0.
REQ-038 16 distinct note-ons, then a 17th -> ch_active=0xFFFF; 17th gives drop=1, tables unchanged; repeating note 60 with a new tw retriggers channel 0 with no drop.
REQ-039 Note-off for an inactive note 99 -> no table change, no drop, no acc_clr; ev_ready returns after 3 cycles.
REQ-040 rst pulsed in LOOKUP after a note-on -> ch_active=0, no acc_clr, scan restarts at channel 0.
